// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller with IE/IF registers and vectored acknowledge.
// Flags set 1 cycle (pulse) or 3 enabled cycles (edge) after src; all state frozen while ce=0.
module irq_ctrl #(
    parameter int                 NUM_SRC   = 5,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = 5'b10001,
    parameter logic [7:0]         VEC_BASE  = 8'h40,
    parameter logic [7:0]         VEC_STEP  = 8'h08,
    parameter logic [7:0]         VEC_NONE  = 8'h55
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [NUM_SRC-1:0] src,
    input  logic               cpu_sel_ie,
    input  logic               cpu_sel_if,
    input  logic               cpu_wr,
    input  logic [7:0]         cpu_di,
    output logic [7:0]         cpu_do,
    input  logic               ack,
    output logic               irq_n,
    output logic [7:0]         vec
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    logic [NUM_SRC-1:0] ie_r;
    logic [NUM_SRC-1:0] if_r;
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;
    logic [NUM_SRC-1:0] sync3;
    logic [NUM_SRC-1:0] arm;
    logic               primed;
    logic [0:0]         ack_state;
    logic [2:0]         lat_idx;
    logic               lat_vld;
    logic [7:0]         lat_vec;

    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] edge_evt;
    logic [NUM_SRC-1:0] pulse_evt;
    logic [NUM_SRC-1:0] set_evt;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] if_next;
    logic               sel_vld;
    logic [2:0]         sel_idx;
    logic [7:0]         sel_vec;
    logic               ack_rise;
    logic               ack_fall;
    logic               wr_ie;
    logic               wr_if;
    logic               unused_di;

    assign unused_di = ^cpu_di;

    // An edge source only counts once it has been seen low after reset, so a
    // line held high through reset release does not fire.
    assign edge_evt  = sync2 & ~sync3 & arm & EDGE_MASK;
    assign pulse_evt = src & ~EDGE_MASK;
    assign set_evt   = edge_evt | pulse_evt;

    assign pend  = ie_r & if_r;
    assign irq_n = ~(|pend);

    // Descending scan so the lowest pending index wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 3'd0;
        sel_vec = VEC_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_vld = 1'b1;
                sel_idx = 3'(i);
                sel_vec = VEC_BASE + 8'(i) * VEC_STEP;
            end
        end
    end

    assign ack_rise = ack && (ack_state == ST_IDLE);
    assign ack_fall = !ack && (ack_state == ST_ACK);

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_mask[i] = ack_fall && lat_vld && (lat_idx == 3'(i));
        end
    end

    assign wr_ie = cpu_wr && cpu_sel_ie;
    assign wr_if = cpu_wr && cpu_sel_if;

    // New source events always win: they are ORed over both a write and a clear.
    assign if_next = wr_if ? (cpu_di[NUM_SRC-1:0] | set_evt)
                           : ((if_r & ~clr_mask) | set_evt);

    // During the first ack cycle the latch is not loaded yet; show the value it will take.
    assign vec = (ack && (ack_state == ST_ACK)) ? lat_vec : sel_vec;

    always_comb begin
        cpu_do = 8'hFF;
        if (cpu_sel_ie) begin
            cpu_do = 8'h00;
            for (int i = 0; i < NUM_SRC; i++) cpu_do[i] = ie_r[i];
        end else if (cpu_sel_if) begin
            for (int i = 0; i < NUM_SRC; i++) cpu_do[i] = if_r[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_r      <= '0;
            if_r      <= '0;
            sync1     <= '0;
            sync2     <= '0;
            sync3     <= '0;
            arm       <= '0;
            primed    <= 1'b0;
            ack_state <= ST_IDLE;
            lat_idx   <= 3'd0;
            lat_vld   <= 1'b0;
            lat_vec   <= VEC_NONE;
        end else if (ce) begin
            sync1  <= src;
            sync2  <= sync1;
            sync3  <= sync2;
            primed <= 1'b1;
            arm    <= arm | ({NUM_SRC{primed}} & ~sync1);
            if_r   <= if_next;
            if (wr_ie) ie_r <= cpu_di[NUM_SRC-1:0];

            case (ack_state)
                ST_IDLE: begin
                    if (ack_rise) begin
                        ack_state <= ST_ACK;
                        lat_idx   <= sel_idx;
                        lat_vld   <= sel_vld;
                        lat_vec   <= sel_vec;
                    end
                end
                default: begin
                    if (ack_fall) begin
                        ack_state <= ST_IDLE;
                        lat_vld   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
